// File: rtl/piso_read_ctrl_if.sv
// rtl/piso_read_ctrl_if.sv - host/shift-register signal bundle for piso_read_ctrl
interface piso_read_ctrl_if #(
  parameter int N = 8
);
  logic         START;
  logic         AUTO;
  logic         QH;
  logic         SH_LD;
  logic         CLK_INH;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] DATA_OUT;

  modport master (
    output START, AUTO, QH,
    input  SH_LD, CLK_INH, BUSY, DONE, DATA_OUT
  );

  modport slave (
    input  START, AUTO, QH,
    output SH_LD, CLK_INH, BUSY, DONE, DATA_OUT
  );
endinterface

// File: rtl/piso_read_ctrl.sv
// rtl/piso_read_ctrl.sv - load/shift sequencer for daisy-chained PISO shift registers
module piso_read_ctrl #(
  parameter int WIDTH     = 8,
  parameter int NUM_DEV   = 1,
  parameter int LD_CYCLES = 1,
  parameter int GAP       = 4
) (
  input logic             CLK,
  input logic             RSTb,
  piso_read_ctrl_if.slave bus
);
  localparam int N  = WIDTH * NUM_DEV;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t         state_q, state_d;
  logic           sh_ld_q, sh_ld_d;
  logic           clk_inh_q, clk_inh_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   data_q, data_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [3:0]     ld_cnt_q, ld_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]     gap_cnt_q, gap_cnt_d;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q   <= IDLE;
      sh_ld_q   <= 1'b1;
      clk_inh_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
      acc_q     <= '0;
      ld_cnt_q  <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sh_ld_q   <= sh_ld_d;
      clk_inh_q <= clk_inh_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      data_q    <= data_d;
      acc_q     <= acc_d;
      ld_cnt_q  <= ld_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_ld_d   = sh_ld_q;
    clk_inh_d = clk_inh_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    data_d    = data_q;
    acc_d     = acc_q;
    ld_cnt_d  = ld_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      IDLE: begin
        sh_ld_d   = 1'b1;
        clk_inh_d = 1'b1;
        // An explicit START wins over whatever gap is still pending.
        if (bus.START || (bus.AUTO && gap_cnt_q == 8'd0)) begin
          state_d  = LOAD;
          sh_ld_d  = 1'b0;
          busy_d   = 1'b1;
          ld_cnt_d = '0;
        end else if (gap_cnt_q != 8'd0) begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      LOAD: begin
        if (ld_cnt_q == 4'(LD_CYCLES - 1)) begin
          state_d   = SHIFT;
          sh_ld_d   = 1'b1;
          clk_inh_d = 1'b0;
          bit_cnt_d = '0;
        end else begin
          ld_cnt_d = ld_cnt_q + 4'd1;
        end
      end

      SHIFT: begin
        // QH is sampled on the same edge that advances the register.
        acc_d     = {acc_q[N-2:0], bus.QH};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BW'(N - 1)) begin
          state_d   = IDLE;
          clk_inh_d = 1'b1;
          data_d    = {acc_q[N-2:0], bus.QH};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          gap_cnt_d = 8'(GAP);
        end
      end

      default: begin
        state_d   = IDLE;
        sh_ld_d   = 1'b1;
        clk_inh_d = 1'b1;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign bus.SH_LD    = sh_ld_q;
  assign bus.CLK_INH  = clk_inh_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.DATA_OUT = data_q;
endmodule

// File: tb/tb_piso_read_ctrl.sv
// tb/tb_piso_read_ctrl.sv - self-checking bench for piso_read_ctrl with 8-bit PISO models
module tb_piso_read_ctrl;
  logic CLK = 1'b0;
  logic RSTb;
  always #5 CLK = ~CLK;

  piso_read_ctrl_if #(.N(8))  ifa ();
  piso_read_ctrl_if #(.N(16)) ifb ();

  piso_read_ctrl #(.WIDTH(8), .NUM_DEV(1), .LD_CYCLES(1), .GAP(4)) dut_a (
    .CLK(CLK), .RSTb(RSTb), .bus(ifa.slave));
  piso_read_ctrl #(.WIDTH(8), .NUM_DEV(2), .LD_CYCLES(2), .GAP(4)) dut_b (
    .CLK(CLK), .RSTb(RSTb), .bus(ifb.slave));

  // Shift-register models: pins are {H,G,F,E,D,C,B,A}, QH = stage H.
  logic [7:0] pins_a = '0, pins_b0 = '0, pins_b1 = '0;
  logic [7:0] sr_a = '0, sr_b0 = '0, sr_b1 = '0;

  always @(posedge CLK) begin
    if (!ifa.SH_LD) sr_a <= pins_a;
    else if (!ifa.CLK_INH) sr_a <= {sr_a[6:0], 1'b0};
    if (!ifb.SH_LD) begin
      sr_b0 <= pins_b0;
      sr_b1 <= pins_b1;
    end else if (!ifb.CLK_INH) begin
      sr_b0 <= {sr_b0[6:0], 1'b0};
      sr_b1 <= {sr_b1[6:0], sr_b0[7]};
    end
  end
  assign ifa.QH = sr_a[7];
  assign ifb.QH = sr_b1[7];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] pins;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ticks until dut_a DONE, returns cycles taken or max+1 on timeout.
  task automatic wait_done_a(input int max, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc <= max) begin
      tick();
      cyc++;
      if (ifa.DONE) seen = 1;
    end
  endtask

  task automatic do_read_a(input string tag, input logic [7:0] exp);
    int ld_low, inh_low, lat, extra;
    bit seen;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    check({tag, "_busy_start"}, 32'(ifa.BUSY), 32'd1);
    ld_low  = ifa.SH_LD ? 0 : 1;
    inh_low = 0;
    lat     = 0;
    seen    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      lat = i;
      if (!ifa.SH_LD) ld_low++;
      if (!ifa.CLK_INH) inh_low++;
      if (ifa.DONE) seen = 1;
    end
    check({tag, "_latency"}, 32'(seen ? lat : 0), 32'd9);
    check({tag, "_sh_ld_low"}, 32'(ld_low), 32'd1);
    check({tag, "_clk_inh_low"}, 32'(inh_low), 32'd8);
    check({tag, "_data"}, 32'(ifa.DATA_OUT), 32'(exp));
    check({tag, "_busy_end"}, 32'(ifa.BUSY), 32'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ifa.DONE) extra++;
    end
    check({tag, "_single_done"}, 32'(extra), 32'd0);
    check({tag, "_data_hold"}, 32'(ifa.DATA_OUT), 32'(exp));
  endtask

  initial begin
    int cyc, cnt, busy_cnt, ld_low;
    bit seen;

    vecs[0] = '{pins: 8'b1101_0101, exp: 8'hD5};
    vecs[1] = '{pins: 8'b1000_0110, exp: 8'h86};
    vecs[2] = '{pins: 8'b1110_0010, exp: 8'hE2};
    vecs[3] = '{pins: 8'b0010_0100, exp: 8'h24};

    RSTb = 1'b0;
    ifa.START = 1'b0; ifa.AUTO = 1'b0;
    ifb.START = 1'b0; ifb.AUTO = 1'b0;
    tick(); tick();
    check("rst_sh_ld", 32'(ifa.SH_LD), 32'd1);
    check("rst_clk_inh", 32'(ifa.CLK_INH), 32'd1);
    check("rst_busy", 32'(ifa.BUSY), 32'd0);
    check("rst_done", 32'(ifa.DONE), 32'd0);
    check("rst_data", 32'(ifa.DATA_OUT), 32'd0);
    RSTb = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) begin
      pins_a = vecs[v].pins;
      do_read_a($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Reset after three SHIFT samples.
    pins_a = 8'hFF;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_busy_before", 32'(ifa.BUSY), 32'd1);
    RSTb = 1'b0;
    #1;
    check("midrst_sh_ld", 32'(ifa.SH_LD), 32'd1);
    check("midrst_clk_inh", 32'(ifa.CLK_INH), 32'd1);
    check("midrst_busy", 32'(ifa.BUSY), 32'd0);
    check("midrst_data", 32'(ifa.DATA_OUT), 32'd0);
    tick();
    RSTb = 1'b1;
    cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.DONE) cnt++;
      if (ifa.BUSY) busy_cnt++;
    end
    check("midrst_no_done", 32'(cnt), 32'd0);
    check("midrst_no_busy", 32'(busy_cnt), 32'd0);

    // START held through the read, still high on the DONE cycle.
    pins_a = 8'hC3;
    ifa.START = 1'b1;
    tick();
    wait_done_a(20, cyc);
    check("hold_first_latency", 32'(cyc), 32'd9);
    check("hold_first_data", 32'(ifa.DATA_OUT), 32'hC3);
    pins_a = 8'h3C;
    tick();
    check("b2b_busy", 32'(ifa.BUSY), 32'd1);
    check("b2b_sh_ld", 32'(ifa.SH_LD), 32'd0);
    ifa.START = 1'b0;
    wait_done_a(20, cyc);
    check("b2b_latency", 32'(cyc), 32'd9);
    check("b2b_data", 32'(ifa.DATA_OUT), 32'h3C);
    for (int i = 0; i < 6; i++) tick();

    // AUTO polling with GAP=4, then drop AUTO mid-SHIFT.
    pins_a = 8'h5A;
    ifa.AUTO = 1'b1;
    wait_done_a(30, cyc);
    check("auto_first_seen", 32'(cyc <= 30), 32'd1);
    check("auto_first_data", 32'(ifa.DATA_OUT), 32'h5A);
    for (int k = 0; k < 2; k++) begin
      wait_done_a(30, cyc);
      check($sformatf("auto_period%0d", k), 32'(cyc), 32'd14);
      check($sformatf("auto_data%0d", k), 32'(ifa.DATA_OUT), 32'h5A);
    end
    for (int i = 0; i < 8; i++) tick();
    check("auto_in_shift", 32'(ifa.BUSY & ifa.SH_LD & ~ifa.CLK_INH), 32'd1);
    ifa.AUTO = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifa.DONE) cnt++;
    end
    check("auto_stop_one_done", 32'(cnt), 32'd1);
    check("auto_stop_data", 32'(ifa.DATA_OUT), 32'h5A);

    // Two chained devices, LD_CYCLES=2.
    pins_b0 = 8'h34;
    pins_b1 = 8'h12;
    ifb.START = 1'b1;
    tick();
    ifb.START = 1'b0;
    ld_low = ifb.SH_LD ? 0 : 1;
    seen = 0; cyc = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      tick();
      cyc = i;
      if (!ifb.SH_LD) ld_low++;
      if (ifb.DONE) seen = 1;
    end
    check("chain_latency", 32'(seen ? cyc : 0), 32'd18);
    check("chain_sh_ld_low", 32'(ld_low), 32'd2);
    check("chain_data", 32'(ifb.DATA_OUT), 32'h1234);
    tick();
    check("chain_done_pulse", 32'(ifb.DONE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
